y86_seq_controller: RTL and testbench

Multi-cycle stage sequencer for the Y86-64 sequential processor. It steps one instruction at a time through fetch, decode, execute, memory, write-back and PC update, and asserts a one-hot enable for each stage. It owns the architectural condition-code register, loaded from the 64-bit ALU flags, and computes the branch/move condition `cnd` from that register. It also tracks processor status and retirement counters. It sits between the top-level core and the stage datapaths (fetch, decode, execute, memory, write-back).

---
 rtl/y86_seq_controller.sv | 207 ++++++++++++++++++++
 tb/tb_y86_seq_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller.sv
// Y86-64 sequential stage sequencer: walks one instruction through F/D/E/M/W/P,
// owns the condition-code register, the branch/move condition and status/counters.
module y86_seq_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic             imem_error,
   input  logic             alu_zf,
   input  logic             alu_sf,
   input  logic             alu_of,
   input  logic             mem_ack,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_req,
   output logic             wb_en,
   output logic             pc_en,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of,
   output logic             cnd,
   output logic [2:0]       stat,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_PCUPD  = 3'd6,
      S_HALTED = 3'd7
   } state_t;

   localparam logic [2:0]       STAT_AOK = 3'd1;
   localparam logic [2:0]       STAT_HLT = 3'd2;
   localparam logic [2:0]       STAT_ADR = 3'd3;
   localparam logic [2:0]       STAT_INS = 3'd4;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     r_state;
   state_t     w_next_state;
   logic [2:0] w_next_stat;
   logic [3:0] r_icode;
   logic [3:0] r_ifun;
   logic       w_cnd;
   logic       w_busy_next;

   function automatic logic f_instr_valid(input logic [3:0] ic, input logic [3:0] fn);
      logic ok;
      case (ic)
         4'h2, 4'h7: ok = (fn <= 4'd6);
         4'h6:       ok = (fn <= 4'd3);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
         4'h8, 4'h9, 4'hA, 4'hB: ok = (fn == 4'd0);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f_cond(input logic [3:0] fn, input logic zf, input logic sf,
                                   input logic of);
      logic c;
      case (fn)
         4'd0:    c = 1'b1;
         4'd1:    c = (sf ^ of) | zf;
         4'd2:    c = sf ^ of;
         4'd3:    c = zf;
         4'd4:    c = ~zf;
         4'd5:    c = ~(sf ^ of);
         4'd6:    c = ~(sf ^ of) & ~zf;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic logic f_is_mem(input logic [3:0] ic);
      logic m;
      case (ic)
         4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: m = 1'b1;
         default:                            m = 1'b0;
      endcase
      return m;
   endfunction

   // Next-state and next-status decode; fetch checks use the live fetch inputs.
   always_comb begin
      w_next_state = r_state;
      w_next_stat  = stat;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FETCH: begin
            if (imem_error) begin
               w_next_state = S_HALTED;
               w_next_stat  = STAT_ADR;
            end else if (!f_instr_valid(icode, ifun)) begin
               w_next_state = S_HALTED;
               w_next_stat  = STAT_INS;
            end else if (icode == 4'h0) begin
               w_next_state = S_HALTED;
               w_next_stat  = STAT_HLT;
            end else begin
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: w_next_state = S_EXEC;
         S_EXEC: begin
            if (f_is_mem(r_icode)) begin
               w_next_state = S_MEM;
            end else begin
               w_next_state = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ack && dmem_error) begin
               w_next_state = S_HALTED;
               w_next_stat  = STAT_ADR;
            end else if (mem_ack) begin
               w_next_state = S_WB;
            end else begin
               w_next_state = S_MEM;
            end
         end
         S_WB:     w_next_state = S_PCUPD;
         S_PCUPD:  w_next_state = S_FETCH;
         S_HALTED: w_next_state = S_HALTED;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Condition uses the CC value held before this cycle's possible update.
   always_comb begin
      if ((r_icode == 4'h2) || (r_icode == 4'h7)) begin
         w_cnd = f_cond(r_ifun, cc_zf, cc_sf, cc_of);
      end else begin
         w_cnd = 1'b0;
      end
      w_busy_next = (w_next_state != S_IDLE) && (w_next_state != S_HALTED);
   end

   // Sequencer state, Moore enables registered from the next state, CC and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_icode   <= 4'h0;
         r_ifun    <= 4'h0;
         fetch_en  <= 1'b0;
         decode_en <= 1'b0;
         exec_en   <= 1'b0;
         mem_req   <= 1'b0;
         wb_en     <= 1'b0;
         pc_en     <= 1'b0;
         busy      <= 1'b0;
         cc_zf     <= 1'b1;
         cc_sf     <= 1'b0;
         cc_of     <= 1'b0;
         cnd       <= 1'b0;
         stat      <= STAT_AOK;
         cycle_cnt <= {CNT_W{1'b0}};
         instr_cnt <= {CNT_W{1'b0}};
      end else begin
         r_state   <= w_next_state;
         fetch_en  <= (w_next_state == S_FETCH);
         decode_en <= (w_next_state == S_DECODE);
         exec_en   <= (w_next_state == S_EXEC);
         mem_req   <= (w_next_state == S_MEM);
         wb_en     <= (w_next_state == S_WB);
         pc_en     <= (w_next_state == S_PCUPD);
         busy      <= w_busy_next;
         stat      <= w_next_stat;
         if (r_state == S_FETCH) begin
            r_icode <= icode;
            r_ifun  <= ifun;
         end
         if (r_state == S_EXEC) begin
            cnd <= w_cnd;
            if (r_icode == 4'h6) begin
               cc_zf <= alu_zf;
               cc_sf <= alu_sf;
               cc_of <= alu_of;
            end
         end
         if ((r_state != S_IDLE) && (r_state != S_HALTED)) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
         end
         if (r_state == S_PCUPD) begin
            instr_cnt <= instr_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_y86_seq_controller.sv
// Self-checking bench for y86_seq_controller: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_y86_seq_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic        imem_error;
   logic        alu_zf, alu_sf, alu_of;
   logic        mem_ack;
   logic        dmem_error;
   logic        fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en;
   logic        cc_zf, cc_sf, cc_of;
   logic        cnd;
   logic [2:0]  stat;
   logic        busy;
   logic [31:0] cycle_cnt, instr_cnt;
   logic [5:0]  en;

   int          n_checks = 0;
   int          n_errors = 0;
   bit          m_zf, m_sf, m_of;
   logic [2:0]  m_stat;
   int unsigned m_cycles, m_instr;
   bit          noise = 1'b0;

   y86_seq_controller #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
      .imem_error(imem_error), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
      .mem_ack(mem_ack), .dmem_error(dmem_error),
      .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_req(mem_req),
      .wb_en(wb_en), .pc_en(pc_en), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
      .cnd(cnd), .stat(stat), .busy(busy), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;
   assign en = {fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int max_ifun(input logic [3:0] ic);
      int tbl[12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};
      if (ic > 4'd11) return -1;
      return tbl[int'(ic)];
   endfunction

   function automatic bit model_valid(input logic [3:0] ic, input logic [3:0] fn);
      return (max_ifun(ic) >= 0) && (int'(fn) <= max_ifun(ic));
   endfunction

   function automatic bit model_cnd(input logic [3:0] fn, input bit z, input bit s, input bit o);
      bit lt = (s != o);
      case (fn)
         4'd0:    return 1'b1;
         4'd1:    return lt || z;
         4'd2:    return lt;
         4'd3:    return z;
         4'd4:    return !z;
         4'd5:    return !lt;
         4'd6:    return !lt && !z;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step();
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_halted(input string tag);
      check({tag, "_stat"}, stat, m_stat);
      check({tag, "_en"}, en, 6'b000000);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_cyc"}, cycle_cnt, m_cycles);
      check({tag, "_icnt"}, instr_cnt, m_instr);
      check({tag, "_cc"}, {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; icode = 4'h0; ifun = 4'h0; imem_error = 1'b0;
      alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
      #2;
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_stat = 3'd1; m_cycles = 0; m_instr = 0;
      check("rst_en", en, 6'b000000);
      check("rst_busy", busy, 1'b0);
      check("rst_cnd", cnd, 1'b0);
      check("rst_stat", stat, 3'd1);
      check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
      check("rst_cyc", cycle_cnt, 0);
      check("rst_icnt", instr_cnt, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      check("idle_en", en, 6'b000000);
   endtask

   task automatic go();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("go_busy", busy, 1'b1);
   endtask

   // Runs one instruction starting in FETCH; returns with the DUT in FETCH or HALTED.
   task automatic do_instr(input logic [3:0] ic, input logic [3:0] fn, input bit imerr,
                           input bit z, input bit s, input bit o, input int n_mem,
                           input bit derr);
      bit is_mem;
      bit exp_cnd;
      check("fetch_en", en, 6'b100000);
      check("cyc_at_fetch", cycle_cnt, m_cycles);
      check("icnt_at_fetch", instr_cnt, m_instr);
      icode = ic; ifun = fn; imem_error = imerr;
      step();
      icode = 4'($urandom); ifun = 4'($urandom); imem_error = 1'b0;
      if (imerr || !model_valid(ic, fn) || ic == 4'h0) begin
         m_stat = imerr ? 3'd3 : (!model_valid(ic, fn) ? 3'd4 : 3'd2);
         m_cycles += 1;
         chk_halted("fetch_halt");
         return;
      end
      check("decode_en", en, 6'b010000);
      step();
      check("exec_en", en, 6'b001000);
      alu_zf = z; alu_sf = s; alu_of = o;
      exp_cnd = (ic == 4'h2 || ic == 4'h7) ? model_cnd(fn, m_zf, m_sf, m_of) : 1'b0;
      if (ic == 4'h6) begin
         m_zf = z; m_sf = s; m_of = o;
      end
      step();
      alu_zf = 1'($urandom); alu_sf = 1'($urandom); alu_of = 1'($urandom);
      check("cnd", cnd, exp_cnd);
      check("cc", {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
      is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      if (is_mem) begin
         for (int i = 1; i <= n_mem; i++) begin
            check("mem_req", en, 6'b000100);
            mem_ack = (i == n_mem);
            dmem_error = (i == n_mem) ? derr : 1'($urandom);
            step();
         end
         mem_ack = 1'b0;
         dmem_error = 1'b0;
         if (derr) begin
            m_stat = 3'd3;
            m_cycles += 3 + n_mem;
            chk_halted("dmem_halt");
            return;
         end
      end
      check("wb_en", en, 6'b000010);
      step();
      check("pc_en", en, 6'b000001);
      step();
      m_instr += 1;
      m_cycles += 5 + (is_mem ? n_mem : 0);
      check("stat_aok", stat, m_stat);
   endtask

   initial begin
      int unsigned cyc0;
      logic [3:0]  ric;
      logic [3:0]  rfn;
      rst_n = 1'b1;
      start = 1'b0;
      #1;

      // single OPq, then conditional jumps and a stalled mrmovq
      do_reset();
      go();
      do_instr(4'h6, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
      check("opq_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
      check("opq_icnt", instr_cnt, 1);
      check("opq_cyc", cycle_cnt, 5);
      do_instr(4'h7, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
      check("jl_cnd", cnd, 1'b1);
      do_instr(4'h7, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0);
      check("jge_cnd", cnd, 1'b0);
      do_instr(4'h7, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      check("jle_cnd", cnd, 1'b1);
      check("jmp_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
      cyc0 = cycle_cnt;
      do_instr(4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      check("mrmov_len", cycle_cnt - cyc0, 8);

      // randomized stream with start noise
      noise = 1'b1;
      for (int k = 0; k < 60; k++) begin
         ric = 4'($urandom_range(1, 11));
         rfn = 4'($urandom_range(0, max_ifun(ric)));
         do_instr(ric, rfn, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(1, 4)), 1'b0);
      end
      noise = 1'b0;

      // rmmovq with a data-memory error, then time spent halted
      do_instr(4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
      end
      chk_halted("dmem_frozen");

      do_reset();
      go();
      do_instr(4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      check("bad_icode_stat", stat, 3'd4);

      do_reset();
      go();
      do_instr(4'h2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      check("bad_ifun_stat", stat, 3'd4);

      do_reset();
      go();
      do_instr(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      check("imem_prio_stat", stat, 3'd3);

      // halt is absorbing despite start pulses
      do_reset();
      go();
      do_instr(4'h6, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      do_instr(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      check("halt_stat", stat, 3'd2);
      for (int i = 0; i < 20; i++) begin
         start = (i % 2 == 0);
         @(posedge clk);
         #1;
         check("halt_en", en, 6'b000000);
         check("halt_busy", busy, 1'b0);
      end
      start = 1'b0;
      chk_halted("halt_end");

      // asynchronous reset in the middle of a MEMORY wait
      do_reset();
      go();
      do_instr(4'h6, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      icode = 4'h5; ifun = 4'h0;
      step();
      step();
      step();
      check("pre_rst_mem", en, 6'b000100);
      check("pre_rst_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_en", en, 6'b000000);
      check("arst_busy", busy, 1'b0);
      check("arst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
      check("arst_cyc", cycle_cnt, 0);
      check("arst_icnt", instr_cnt, 0);
      check("arst_stat", stat, 3'd1);
      #3;
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
